systolic_input_skewer: RTL and testbench

//   Upstream feeder for the 3x3 weight-stationary systolic array. Buffers incoming

---
 rtl/systolic_input_skewer.sv | 145 ++++++++++++++
 tb/tb_systolic_input_skewer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_input_skewer.sv
// rtl/systolic_input_skewer.sv - tile FIFO plus diagonal-wavefront skew feeder for a weight-stationary systolic array
// Optional feature macro: SKEW_STALL_CNT_EN (adds stall_cnt output)
module systolic_input_skewer #(
    parameter int DATA_W     = 32,
    parameter int ROWS       = 3,
    parameter int VECS       = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef SKEW_STALL_CNT_EN
    output logic [15:0]              stall_cnt,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROWS*DATA_W-1:0]   in_data,
    output logic [ROWS*DATA_W-1:0]   west_data,
    output logic [ROWS-1:0]          west_valid,
    output logic                     busy,
    output logic                     tile_done
);

    localparam int PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW      = $clog2(FIFO_DEPTH + 1);
    localparam int DRAIN_CYC = 2 * ROWS - 2;
    localparam int PH_MAX    = (VECS > DRAIN_CYC) ? VECS : DRAIN_CYC;
    localparam int PHW       = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t                  state, state_next;
    logic [PHW-1:0]          phase, phase_next;

    logic [ROWS*DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [CNTW-1:0]         count;
    logic                    push, pop;

    // Ready depends only on the registered count, so a full FIFO never accepts even while popping.
    assign in_ready  = (count < CNTW'(FIFO_DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (state == STREAM);
    assign busy      = (state != IDLE);
    assign tile_done = (state == DONE);

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    // FIFO pointers and occupancy; a reset discards anything buffered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + {{(CNTW-1){1'b0}}, push} - {{(CNTW-1){1'b0}}, pop};
        end
    end

    // Tile sequencer state and phase counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    // Start only on a fully buffered tile since the array cannot absorb bubbles.
    always_comb begin
        state_next = state;
        phase_next = phase;
        case (state)
            IDLE: begin
                if (count >= CNTW'(VECS)) begin
                    state_next = STREAM;
                    phase_next = '0;
                end
            end
            STREAM: begin
                if (phase == PHW'(VECS - 1)) begin
                    state_next = DRAIN;
                    phase_next = '0;
                end else begin
                    phase_next = phase + 1'b1;
                end
            end
            DRAIN: begin
                if (phase == PHW'(DRAIN_CYC - 1)) begin
                    state_next = DONE;
                    phase_next = '0;
                end else begin
                    phase_next = phase + 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Row r is a chain of r+1 registers; zeros enter whenever nothing is popped.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_W-1:0] sd [r+1];
        logic [r:0]        sv;

        // Shift the row's data/valid chain one stage per cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int j = 0; j <= r; j++)
                    sd[j] <= '0;
                sv <= '0;
            end else begin
                sd[0] <= pop ? mem[rd_ptr][r*DATA_W +: DATA_W] : '0;
                sv[0] <= pop;
                for (int j = 1; j <= r; j++) begin
                    sd[j] <= sd[j-1];
                    sv[j] <= sv[j-1];
                end
            end
        end

        assign west_data[r*DATA_W +: DATA_W] = sd[r];
        assign west_valid[r]                 = sv[r];
    end

`ifdef SKEW_STALL_CNT_EN
    // Count idle cycles spent waiting on a partially buffered tile, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (state == IDLE && count != '0 && count < CNTW'(VECS) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_systolic_input_skewer.sv
// tb/tb_systolic_input_skewer.sv - randomized self-checking bench for systolic_input_skewer
module tb_systolic_input_skewer;

    localparam int DW   = 32;
    localparam int R    = 3;
    localparam int V    = 3;
    localparam int FD   = 4;
    localparam int W    = R * DW;
    localparam int TLEN = V + 2 * R - 2;   // cycles from first STREAM cycle to DONE
    localparam int MAXN = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  west_data;
    logic [R-1:0]  west_valid;
    logic          busy;
    logic          tile_done;
`ifdef SKEW_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    systolic_input_skewer #(.DATA_W(DW), .ROWS(R), .VECS(V), .FIFO_DEPTH(FD)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SKEW_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .west_data  (west_data),
        .west_valid (west_valid),
        .busy       (busy),
        .tile_done  (tile_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Timeline reference: FIFO as a queue, tile start time, per-cycle expected west outputs.
    logic [W-1:0] q[$];
    int           n;
    int           s;
    bit           s_valid;
    logic [W-1:0] exp_wd [MAXN];
    logic [R-1:0] exp_wv [MAXN];
    int           stall_m;

    task automatic model_clear();
        q.delete();
        n = 0;
        s = 0;
        s_valid = 0;
        stall_m = 0;
        for (int i = 0; i < MAXN; i++) begin
            exp_wd[i] = '0;
            exp_wv[i] = '0;
        end
    endtask

    function automatic logic [W-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    // Check one cycle of outputs, apply inputs, advance the reference model and the clock.
    task automatic step(input bit v, input logic [W-1:0] d, output bit acc);
        bit busy_e, done_e, rdy_e;
        int qs0;
        logic [W-1:0] vec;
        if (n >= MAXN - R - 2) begin
            $display("FAIL cycle_budget: cycle %0d exceeds bound %0d", n, MAXN);
            errors++;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $fatal(1, "cycle budget exhausted");
        end
        qs0    = q.size();
        rdy_e  = (qs0 < FD);
        busy_e = s_valid && (n >= s) && (n <= s + TLEN);
        done_e = s_valid && (n == s + TLEN);
        checks++; if (in_ready !== rdy_e) begin errors++; $display("FAIL in_ready: got %b expected %b cycle %0d", in_ready, rdy_e, n); end
        checks++; if (busy !== busy_e) begin errors++; $display("FAIL busy: got %b expected %b cycle %0d", busy, busy_e, n); end
        checks++; if (tile_done !== done_e) begin errors++; $display("FAIL tile_done: got %b expected %b cycle %0d", tile_done, done_e, n); end
        checks++; if (west_valid !== exp_wv[n]) begin errors++; $display("FAIL west_valid: got %b expected %b cycle %0d", west_valid, exp_wv[n], n); end
        checks++; if (west_data !== exp_wd[n]) begin errors++; $display("FAIL west_data: got %h expected %h cycle %0d", west_data, exp_wd[n], n); end
`ifdef SKEW_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'(stall_m)) begin errors++; $display("FAIL stall_cnt: got %0d expected %0d cycle %0d", stall_cnt, stall_m, n); end
`endif
        in_valid = v;
        in_data  = d;
        acc = v && rdy_e;
        if (s_valid && n >= s && n < s + V) begin
            vec = q.pop_front();
            for (int r = 0; r < R; r++) begin
                exp_wv[n + r + 1][r] = 1'b1;
                exp_wd[n + r + 1][r*DW +: DW] = vec[r*DW +: DW];
            end
        end
        if (acc) q.push_back(d);
        if (!busy_e && qs0 > 0 && qs0 < V && stall_m < 16'hFFFF) stall_m++;
        if (!busy_e && qs0 >= V) begin
            s = n + 1;
            s_valid = 1;
        end
        @(posedge clk);
        #1;
        n++;
    endtask

    // Offer a vector with in_valid held until accepted, as upstream must.
    task automatic send(input logic [W-1:0] d);
        bit acc;
        acc = 0;
        for (int t = 0; t < 40 && !acc; t++) step(1, d, acc);
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: vector %h not accepted in 40 cycles", d);
        end
    endtask

    task automatic idle(input int cycles);
        bit acc;
        for (int t = 0; t < cycles; t++) step(0, '0, acc);
    endtask

    // Assert reset mid-cycle, check outputs clear immediately, release after the next edge.
    task automatic do_reset();
        in_valid = 0;
        in_data  = '0;
        #2 rst = 1'b1;
        #1;
        checks++; if (west_data !== '0) begin errors++; $display("FAIL rst_west_data: got %h expected 0", west_data); end
        checks++; if (west_valid !== '0) begin errors++; $display("FAIL rst_west_valid: got %b expected 0", west_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL rst_tile_done: got %b expected 0", tile_done); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
`ifdef SKEW_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        idle(3);
    endtask

    task automatic test_single_tile();
        do_reset();
        send({32'd3, 32'd2, 32'd1});
        send({32'd6, 32'd5, 32'd4});
        send({32'd9, 32'd8, 32'd7});
        idle(TLEN + 6);
    endtask

    task automatic test_partial();
        do_reset();
        send(rand_vec());
        idle(10);
`ifdef SKEW_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_after_10: got %0d expected 10", stall_cnt); end
`endif
        send(rand_vec());
        idle(6);
        send(rand_vec());
        idle(TLEN + 6);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) send(rand_vec());
        idle(2 * TLEN + 8);
    endtask

    task automatic test_reset_mid();
        bit reached;
        do_reset();
        for (int i = 0; i < V; i++) send(rand_vec());
        reached = 0;
        for (int t = 0; t < 20 && !reached; t++) begin
            if (s_valid && n == s + 1) reached = 1;
            else idle(1);
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL reach_stream1: got cycle %0d expected stream cycle 1", n); end
        do_reset();
        for (int i = 0; i < V; i++) send(rand_vec());
        idle(TLEN + 6);
    endtask

    task automatic test_random();
        bit acc;
        logic [W-1:0] d;
        bit pending;
        do_reset();
        pending = 0;
        d = '0;
        for (int t = 0; t < 400; t++) begin
            if (!pending && ($urandom_range(0, 99) < 60)) begin
                d = rand_vec();
                pending = 1;
            end
            step(pending, d, acc);
            if (acc) pending = 0;
        end
        idle(2 * TLEN + 10);
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_single_tile();
        test_partial();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
